// File: rtl/pool_ctrl_if.sv
// Handshake and address bus between pool_ctrl and its system: run enable in,
// feature-map reads, save strobes and status out.
interface pool_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              en_ctrl;
  logic [ADDR_W-1:0] r_addr;
  logic              r_valid;
  logic              first;
  logic              save;
  logic [ADDR_W-1:0] save_addr;
  logic              busy;
  logic              finish;

  modport master (
    output en_ctrl,
    input  r_addr, r_valid, first, save, save_addr, busy, finish
  );

  modport slave (
    input  en_ctrl,
    output r_addr, r_valid, first, save, save_addr, busy, finish
  );
endinterface

// File: rtl/pool_ctrl.sv
// Max-pooling sequencer: walks every POOLxPOOL window of every channel, issuing
// one read per cycle and one save strobe per window.
//
// state | meaning
// IDLE  | waiting for en_ctrl, outputs 0
// READ  | issuing window element reads (pauses while en_ctrl=0)
// SAVE  | one-cycle save strobe for the finished window
// DONE  | finish=1 until en_ctrl drops
module pool_ctrl #(
  parameter int              IMG_W    = 28,
  parameter int              IMG_H    = 28,
  parameter int              CHANNELS = 6,
  parameter int              POOL     = 2,
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] IN_BASE  = '0,
  parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'('h1000)
) (
  input  logic       clk,
  input  logic       reset,
  pool_ctrl_if.slave bus
);

  localparam int OW   = IMG_W / POOL;
  localparam int OH   = IMG_H / POOL;
  localparam int NWIN = CHANNELS * OH * OW;
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int XW   = (OW > 1) ? $clog2(OW) : 1;
  localparam int YW   = (OH > 1) ? $clog2(OH) : 1;
  localparam int KW   = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int IW   = (NWIN > 1) ? $clog2(NWIN) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(CHANNELS - 1);
  localparam logic [XW-1:0] X_LAST = XW'(OW - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OH - 1);
  localparam logic [KW-1:0] K_LAST = KW'(POOL - 1);

  typedef enum logic [1:0] {IDLE, READ, SAVE, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   c_q, c_d;
  logic [YW-1:0]   oy_q, oy_d;
  logic [XW-1:0]   ox_q, ox_d;
  logic [KW-1:0]   ky_q, ky_d;
  logic [KW-1:0]   kx_q, kx_d;
  logic [IW-1:0]   oidx_q, oidx_d;

  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [ADDR_W-1:0] save_addr_q, save_addr_d;
  logic              r_valid_q, r_valid_d;
  logic              first_q, first_d;
  logic              save_q, save_d;
  logic              busy_q, busy_d;
  logic              finish_q, finish_d;

  function automatic logic [ADDR_W-1:0] rd_addr(
    input logic [CW-1:0] c, input logic [YW-1:0] oy, input logic [XW-1:0] ox,
    input logic [KW-1:0] ky, input logic [KW-1:0] kx);
    logic [31:0] a;
    a = 32'(IN_BASE) + 32'(c) * 32'(IMG_W * IMG_H)
      + (32'(oy) * 32'(POOL) + 32'(ky)) * 32'(IMG_W)
      + 32'(ox) * 32'(POOL) + 32'(kx);
    return a[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] wr_addr(input logic [IW-1:0] oidx);
    logic [31:0] a;
    a = 32'(OUT_BASE) + 32'(oidx);
    return a[ADDR_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      c_q         <= '0;
      oy_q        <= '0;
      ox_q        <= '0;
      ky_q        <= '0;
      kx_q        <= '0;
      oidx_q      <= '0;
      r_addr_q    <= '0;
      save_addr_q <= '0;
      r_valid_q   <= 1'b0;
      first_q     <= 1'b0;
      save_q      <= 1'b0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      oy_q        <= oy_d;
      ox_q        <= ox_d;
      ky_q        <= ky_d;
      kx_q        <= kx_d;
      oidx_q      <= oidx_d;
      r_addr_q    <= r_addr_d;
      save_addr_q <= save_addr_d;
      r_valid_q   <= r_valid_d;
      first_q     <= first_d;
      save_q      <= save_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
    end
  end

  // Counters always name the element currently shown on r_addr; a pause holds
  // them, so resuming advances to the next element without skip or repeat.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    ky_d    = ky_q;
    kx_d    = kx_q;
    oidx_d  = oidx_q;

    unique case (state_q)
      IDLE: if (bus.en_ctrl) state_d = READ;
      READ: begin
        if (bus.en_ctrl) begin
          if (kx_q == K_LAST) begin
            kx_d = '0;
            if (ky_q == K_LAST) begin
              ky_d    = '0;
              state_d = SAVE;
            end else begin
              ky_d = ky_q + 1'b1;
            end
          end else begin
            kx_d = kx_q + 1'b1;
          end
        end
      end
      SAVE: begin
        oidx_d  = oidx_q + 1'b1;
        state_d = READ;
        if (ox_q == X_LAST) begin
          ox_d = '0;
          if (oy_q == Y_LAST) begin
            oy_d = '0;
            if (c_q == C_LAST) begin
              c_d     = '0;
              oidx_d  = '0;
              state_d = DONE;
            end else begin
              c_d = c_q + 1'b1;
            end
          end else begin
            oy_d = oy_q + 1'b1;
          end
        end else begin
          ox_d = ox_q + 1'b1;
        end
      end
      DONE: if (!bus.en_ctrl) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The first read of a window is issued straight out of SAVE; pausing only
    // takes effect on READ cycles.
    r_valid_d   = (state_d == READ) && !((state_q == READ) && !bus.en_ctrl);
    first_d     = r_valid_d && (kx_d == '0) && (ky_d == '0);
    r_addr_d    = (state_d == READ) ? rd_addr(c_d, oy_d, ox_d, ky_d, kx_d) : '0;
    save_d      = (state_d == SAVE);
    save_addr_d = save_d ? wr_addr(oidx_d) : '0;
    busy_d      = (state_d == READ) || (state_d == SAVE);
    finish_d    = (state_d == DONE);
  end

  assign bus.r_addr    = r_addr_q;
  assign bus.r_valid   = r_valid_q;
  assign bus.first     = first_q;
  assign bus.save      = save_q;
  assign bus.save_addr = save_addr_q;
  assign bus.busy      = busy_q;
  assign bus.finish    = finish_q;

endmodule
